// File: rtl/encode_83_if.sv
// Request-vector / encoded-index bundle for the registered 8-to-3 priority encoder.
// Handshake: no valid/ready; the producer drives en and d, and the encoder presents a/valid/multi one cycle after each enabled capture.
interface encode_83_if;
   logic       en;
   logic [7:0] d;
   logic [2:0] a;
   logic       valid;
   logic       multi;

   modport master (output en, d, input a, valid, multi);
   modport slave  (input en, d, output a, valid, multi);
endinterface

// File: rtl/encode_83.sv
// Registered 8-to-3 priority encoder with invalid-input flags.
// a/valid/multi are pure flops, captured from d on each enabled clock edge.
module encode_83 #(
   parameter bit LSB_PRIORITY = 1'b0
) (
   input  logic       clk,
   input  logic       rst,
   encode_83_if.slave bus
);

   logic [2:0] w_idx;
   logic       w_any;
   logic       w_multi;

   logic [2:0] r_a;
   logic       r_valid;
   logic       r_multi;

   // The last matching bit in the scan order wins, so the scan direction selects the priority.
   always_comb begin
      w_idx = 3'd0;
      if (LSB_PRIORITY) begin
         for (int i = 7; i >= 0; i--) begin
            if (bus.d[i]) w_idx = 3'(i);
         end
      end else begin
         for (int i = 0; i < 8; i++) begin
            if (bus.d[i]) w_idx = 3'(i);
         end
      end
   end

   assign w_any   = |bus.d;
   // Clearing the lowest set bit leaves something only when two or more bits were set.
   assign w_multi = |(bus.d & (bus.d - 8'd1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_a     <= 3'd0;
         r_valid <= 1'b0;
         r_multi <= 1'b0;
      end else if (bus.en) begin
         r_a     <= w_idx;
         r_valid <= w_any;
         r_multi <= w_multi;
      end
   end

   assign bus.a     = r_a;
   assign bus.valid = r_valid;
   assign bus.multi = r_multi;

endmodule

// File: tb/tb_encode_83.sv
// Bench for encode_83: an MSB-priority and an LSB-priority instance share the same stimulus.
// The expected output of each instance comes from an arithmetic reference model.
module tb_encode_83;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   encode_83_if bus_m ();
   encode_83_if bus_l ();

   encode_83 #(.LSB_PRIORITY(1'b0)) u_msb (.clk(clk), .rst(rst), .bus(bus_m));
   encode_83 #(.LSB_PRIORITY(1'b1)) u_lsb (.clk(clk), .rst(rst), .bus(bus_l));

   // Packed as {a, valid, multi}; index 0 = MSB instance, index 1 = LSB instance.
   logic [4:0] obs   [2];
   logic [4:0] exp_s [2];

   assign obs[0] = {bus_m.a, bus_m.valid, bus_m.multi};
   assign obs[1] = {bus_l.a, bus_l.valid, bus_l.multi};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [4:0] ref_encode(input logic [7:0] d, input bit lsb);
      int v;
      int idx;
      int cnt;
      logic [2:0] a3;
      v   = int'(d);
      cnt = $countones(d);
      if (cnt == 0) return 5'b0;
      if (lsb) idx = $clog2(v & -v);
      else     idx = $clog2(v + 1) - 1;
      a3 = idx[2:0];
      return {a3, 1'b1, (cnt > 1)};
   endfunction

   // Applies one cycle of stimulus to both instances, then advances the model after the edge.
   task automatic drive(input logic [7:0] d, input logic en, input logic r);
      bus_m.d  = d;
      bus_l.d  = d;
      bus_m.en = en;
      bus_l.en = en;
      rst      = r;
      @(posedge clk);
      #1;
      for (int k = 0; k < 2; k++) begin
         if (r)       exp_s[k] = 5'b0;
         else if (en) exp_s[k] = ref_encode(d, (k == 1));
      end
   endtask

   task automatic test_reset();
      for (int c = 0; c < 2; c++) begin
         drive(8'hFF, 1'b1, 1'b1);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== 5'b0) begin
               n_fail++;
               $display("FAIL reset dut%0d cyc%0d got=%b exp=%b", k, c, obs[k], 5'b0);
            end
         end
      end
      drive(8'hFF, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== {(k == 0) ? 3'd7 : 3'd0, 2'b11}) begin
            n_fail++;
            $display("FAIL reset_release dut%0d got=%b exp_a=%0d valid=1 multi=1", k, obs[k], (k == 0) ? 7 : 0);
         end
      end
   endtask

   task automatic test_one_hot();
      logic [7:0] din [8];
      logic [2:0] aexp [8];
      din  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h10, 8'h40, 8'h80};
      aexp = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd6, 3'd7};
      for (int i = 0; i < 8; i++) begin
         drive(din[i], 1'b1, 1'b0);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== {aexp[i], 2'b10}) begin
               n_fail++;
               $display("FAIL one_hot dut%0d d=%h got=%b exp=%b", k, din[i], obs[k], {aexp[i], 2'b10});
            end
         end
      end
   endtask

   task automatic test_zero();
      drive(8'h00, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== 5'b0) begin
            n_fail++;
            $display("FAIL zero dut%0d got=%b exp=%b", k, obs[k], 5'b0);
         end
      end
      drive(8'h01, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== 5'b00010) begin
            n_fail++;
            $display("FAIL zero_then_01 dut%0d got=%b exp=%b", k, obs[k], 5'b00010);
         end
      end
   endtask

   task automatic test_priority();
      drive(8'b1010_0100, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== {(k == 0) ? 3'd7 : 3'd2, 2'b11}) begin
            n_fail++;
            $display("FAIL priority_a4 dut%0d got=%b exp_a=%0d valid=1 multi=1", k, obs[k], (k == 0) ? 7 : 2);
         end
      end
      drive(8'h03, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== {(k == 0) ? 3'd1 : 3'd0, 2'b11}) begin
            n_fail++;
            $display("FAIL priority_03 dut%0d got=%b exp_a=%0d valid=1 multi=1", k, obs[k], (k == 0) ? 1 : 0);
         end
      end
   endtask

   task automatic test_enable_hold();
      drive(8'h20, 1'b1, 1'b0);
      for (int c = 0; c < 3; c++) begin
         drive(8'h02, 1'b0, 1'b0);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== 5'b10110) begin
               n_fail++;
               $display("FAIL enable_hold dut%0d cyc%0d got=%b exp=%b", k, c, obs[k], 5'b10110);
            end
         end
      end
      drive(8'h02, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== 5'b00110) begin
            n_fail++;
            $display("FAIL enable_resume dut%0d got=%b exp=%b", k, obs[k], 5'b00110);
         end
      end
   endtask

   task automatic test_reset_mid();
      drive(8'h80, 1'b1, 1'b0);
      drive(8'h80, 1'b1, 1'b1);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_mid dut%0d got=%b exp=%b", k, obs[k], 5'b0);
         end
      end
      drive(8'h80, 1'b1, 1'b0);
      for (int k = 0; k < 2; k++) begin
         n_cmp++;
         if (obs[k] !== 5'b11110) begin
            n_fail++;
            $display("FAIL reset_mid_release dut%0d got=%b exp=%b", k, obs[k], 5'b11110);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic       en;
      logic       r;
      for (int i = 0; i < 300; i++) begin
         case ($urandom_range(0, 3))
            0:       d = 8'h00;
            1:       d = 8'(1 << $urandom_range(0, 7));
            default: d = 8'($urandom);
         endcase
         en = ($urandom_range(0, 3) != 0);
         r  = ($urandom_range(0, 15) == 0);
         drive(d, en, r);
         for (int k = 0; k < 2; k++) begin
            n_cmp++;
            if (obs[k] !== exp_s[k]) begin
               n_fail++;
               $display("FAIL random dut%0d i=%0d d=%h en=%b rst=%b got=%b exp=%b", k, i, d, en, r, obs[k], exp_s[k]);
            end
         end
      end
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      exp_s  = '{5'b0, 5'b0};
      rst    = 1'b1;
      test_reset();
      test_one_hot();
      test_zero();
      test_priority();
      test_enable_hold();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/encode_83.md
Name: encode_83

Overview:
- Registered 8-to-3 priority encoder.
- Converts an 8-bit request/one-hot vector `d` into a 3-bit binary index `a`.
- Flags invalid input: all-zero input, or more than one bit set.
- Sits between request/decode logic and index-consuming datapaths. Outputs are registered, so downstream logic gets glitch-free, clock-aligned values.

Parameters:
- LSB_PRIORITY, 0, when 0 the highest-numbered set bit wins; when 1 the lowest-numbered set bit wins.

Ports:
- clk    input   1  rising-edge clock; all state updates on posedge clk
- rst    input   1  synchronous, active-high reset
- en     input   1  capture enable; when low, outputs hold their values
- d      input   8  input vector, bit i = request i
- a      output  3  encoded index of the winning bit (registered)
- valid  output  1  registered; 1 when the captured d had at least one bit set
- multi  output  1  registered; 1 when the captured d had two or more bits set

Behaviour:
- One clock; reset is synchronous and active-high.
  - rst sampled on posedge clk.
  - rst has priority over en.
- Reset values: a = 3'b000, valid = 0, multi = 0.
- Capture rule: at posedge clk with rst=0 and en=1, all outputs update from the current d.
- Latency is exactly 1 cycle from d to a/valid/multi.
- At posedge clk with rst=0 and en=0, a/valid/multi hold their previous values.
- Encoding, one-hot input: a = index of the set bit.
  - 8'h01→0, 8'h02→1, 8'h04→2, 8'h08→3, 8'h10→4, 8'h20→5, 8'h40→6, 8'h80→7.
  - valid=1, multi=0.
- Encoding, multi-hot input:
  - LSB_PRIORITY=0: a = index of the highest set bit.
  - LSB_PRIORITY=1: a = index of the lowest set bit.
  - valid=1, multi=1.
- Encoding, all-zero input: a = 3'b000, valid=0, multi=0.
  - a=0 with valid=0 is distinguishable from d=8'h01 (a=0, valid=1).
- Outputs are purely registered. No combinational path from d, en or rst to any output.
- The next-state function is combinational on d only, with no dependence on previous outputs apart from the hold on en=0.
- Reset asserted mid-stream: on the next posedge, outputs go to reset values regardless of d or en.
- After reset deasserts, the first capture occurs on the first posedge with en=1.
- X or Z on d while en=1 is not defined. A bench must not drive it and the design does not check for it.

Test Plan:
- Reset: rst=1 for 2 cycles with d=8'hFF, en=1 → a=0, valid=0, multi=0 after each edge. Release rst → next edge a=7, valid=1, multi=1.
- One-hot sweep (LSB_PRIORITY=0, en=1):
  - d = 8'h01, 02, 04, 08, 10, 10, 40, 80, each held ≥1 cycle.
  - One cycle later a = 0, 1, 2, 3, 4, 4, 6, 7.
  - valid=1 and multi=0 throughout.
  - The repeated 8'h10 entry checks a repeated input still gives 4.
- Zero input: d=8'h00 → a=0, valid=0, multi=0. Then d=8'h01 → a=0, valid=1.
- Priority: d=8'b1010_0100.
  - LSB_PRIORITY=0 → a=7, multi=1.
  - LSB_PRIORITY=1 → a=2, multi=1.
  - d=8'h03 → a=1 (MSB mode) or 0 (LSB mode).
- Enable hold: capture d=8'h20 (a=5), then drop en and drive d=8'h02 for 3 cycles → a stays 5, valid=1. Raise en → next edge a=1.
- Reset mid-operation: en=1, d=8'h80 (a=7); assert rst for one cycle with en=1 → a=0, valid=0. Deassert rst → next edge a=7, valid=1.
